// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback / mul-div block.
package wb_pkg;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_REG   = 3'd1,
      OP_MULT  = 3'd2,
      OP_MULTU = 3'd3,
      OP_DIV   = 3'd4,
      OP_DIVU  = 3'd5,
      OP_MTHI  = 3'd6,
      OP_MTLO  = 3'd7
   } wb_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } wb_state_t;

   localparam int          ITER_DEFAULT = 32;
   localparam logic [31:0] DIV0_LO      = 32'hFFFF_FFFF;

   function automatic logic is_muldiv(input wb_op_t op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative 32x32 multiply / divide engine: shift-add multiply and
// restoring divide on operand magnitudes, one bit per cycle, with sign
// fix-up folded into the final step so the result is ready on the done pulse.
module muldiv_iter
   import wb_pkg::*;
#(
   parameter int ITER = ITER_DEFAULT
) (
   input  logic        clk,
   input  logic        CLR_n,
   input  logic        start,
   input  wb_op_t      op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

   logic [31:0]   hi_q, lo_q, mcand_q, a_raw_q;
   logic [CW-1:0] cnt_q;
   logic          run_q, is_div_q, neg_hi_q, neg_lo_q, div0_q;

   logic          sgn, a_neg, b_neg, start_div;
   logic [31:0]   a_mag, b_mag;
   logic [32:0]   sum, rs, diff;
   logic [31:0]   nxt_hi, nxt_lo;
   logic [63:0]   prod_neg;

   // Operand magnitudes and sign flags captured at start.
   always_comb begin
      sgn       = (op == OP_MULT) || (op == OP_DIV);
      start_div = (op == OP_DIV) || (op == OP_DIVU);
      a_neg     = sgn & a[31];
      b_neg     = sgn & b[31];
      a_mag     = a_neg ? -a : a;
      b_mag     = b_neg ? -b : b;
   end

   // One iteration: hi_q is the partial product / partial remainder,
   // lo_q shifts multiplier bits out or quotient bits in.
   always_comb begin
      sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : 33'd0);
      rs   = {hi_q, lo_q[31]};
      diff = rs - {1'b0, mcand_q};
      if (is_div_q) begin
         nxt_hi = diff[32] ? rs[31:0] : diff[31:0];
         nxt_lo = {lo_q[30:0], ~diff[32]};
      end else begin
         nxt_hi = sum[32:1];
         nxt_lo = {sum[0], lo_q[31:1]};
      end
   end

   // Final result: divide-by-zero override, then sign correction.
   always_comb begin
      prod_neg = -{nxt_hi, nxt_lo};
      hi       = nxt_hi;
      lo       = nxt_lo;
      if (div0_q) begin
         hi = a_raw_q;
         lo = DIV0_LO;
      end else if (is_div_q) begin
         if (neg_hi_q) hi = -nxt_hi;
         if (neg_lo_q) lo = -nxt_lo;
      end else if (neg_lo_q) begin
         hi = prod_neg[63:32];
         lo = prod_neg[31:0];
      end
   end

   assign done = run_q && (cnt_q == '0);

   // Operand latch on start, then one step per cycle under a down-counter.
   always_ff @(posedge clk or negedge CLR_n) begin
      if (!CLR_n) begin
         hi_q     <= '0;
         lo_q     <= '0;
         mcand_q  <= '0;
         a_raw_q  <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
         is_div_q <= 1'b0;
         neg_hi_q <= 1'b0;
         neg_lo_q <= 1'b0;
         div0_q   <= 1'b0;
      end else if (start) begin
         run_q    <= 1'b1;
         cnt_q    <= CW'(ITER - 1);
         is_div_q <= start_div;
         hi_q     <= '0;
         a_raw_q  <= a;
         div0_q   <= start_div && (b == 32'd0);
         neg_lo_q <= a_neg ^ b_neg;
         if (start_div) begin
            lo_q     <= a_mag;
            mcand_q  <= b_mag;
            neg_hi_q <= a_neg;
         end else begin
            lo_q     <= b_mag;
            mcand_q  <= a_mag;
            neg_hi_q <= a_neg ^ b_neg;
         end
      end else if (run_q) begin
         hi_q <= nxt_hi;
         lo_q <= nxt_lo;
         if (cnt_q == '0) run_q <= 1'b0;
         else             cnt_q <= cnt_q - CW'(1);
      end
   end

endmodule

// File: rtl/wb_muldiv.sv
// Writeback producer: handshake with MEM, single-cycle register/HI/LO
// write pulses, and sequencing of the iterative mul/div engine.
//
//  state   | meaning
//  --------+------------------------------------------------------
//  ST_IDLE | ready for a new operation; single-cycle ops stay here
//  ST_BUSY | mul/div engine iterating
//  ST_DONE | HI/LO write pulse on the outputs; back to IDLE next
module wb_muldiv
   import wb_pkg::*;
#(
   parameter int ITER = ITER_DEFAULT
) (
   input  logic        clk,
   input  logic        CLR_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_op,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic [4:0]  in_dst,
   output logic [31:0] WbData,
   output logic [4:0]  WbRegNum,
   output logic        RegWrite,
   output logic [31:0] HI_in,
   output logic        HIWrite,
   output logic        LOWrite,
   output logic        md_busy
);

   wb_state_t   state_q, state_d;
   wb_op_t      op;
   logic        accept, start_md, md_done;
   logic [31:0] md_hi, md_lo;

   assign op       = wb_op_t'(in_op);
   assign in_ready = (state_q == ST_IDLE);
   assign md_busy  = (state_q != ST_IDLE);
   assign accept   = in_valid && in_ready;
   assign start_md = accept && is_muldiv(op);

   muldiv_iter #(.ITER(ITER)) u_engine (
      .clk   (clk),
      .CLR_n (CLR_n),
      .start (start_md),
      .op    (op),
      .a     (in_a),
      .b     (in_b),
      .done  (md_done),
      .hi    (md_hi),
      .lo    (md_lo)
   );

   // State register.
   always_ff @(posedge clk or negedge CLR_n) begin
      if (!CLR_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_md) state_d = ST_BUSY;
         ST_BUSY: if (md_done)  state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Registered write pulses; everything returns to zero when no write.
   always_ff @(posedge clk or negedge CLR_n) begin
      if (!CLR_n) begin
         WbData   <= '0;
         WbRegNum <= '0;
         RegWrite <= 1'b0;
         HI_in    <= '0;
         HIWrite  <= 1'b0;
         LOWrite  <= 1'b0;
      end else begin
         WbData   <= '0;
         WbRegNum <= '0;
         RegWrite <= 1'b0;
         HI_in    <= '0;
         HIWrite  <= 1'b0;
         LOWrite  <= 1'b0;
         if (state_q == ST_BUSY && md_done) begin
            HI_in   <= md_hi;
            WbData  <= md_lo;
            HIWrite <= 1'b1;
            LOWrite <= 1'b1;
         end else if (accept) begin
            case (op)
               OP_REG: begin
                  WbData   <= in_a;
                  WbRegNum <= in_dst;
                  RegWrite <= (in_dst != 5'd0);
               end
               OP_MTHI: begin
                  HI_in   <= in_a;
                  HIWrite <= 1'b1;
               end
               OP_MTLO: begin
                  WbData  <= in_a;
                  LOWrite <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_wb_muldiv.sv
// Self-checking bench for wb_muldiv: directed vector table, hand-written
// corner sequences, and randomized operations against an arithmetic model.
module tb_wb_muldiv;
   import wb_pkg::*;

   localparam int ITER = 32;

   logic        clk = 1'b0;
   logic        CLR_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [31:0] in_a, in_b;
   logic [4:0]  in_dst;
   logic [31:0] WbData;
   logic [4:0]  WbRegNum;
   logic        RegWrite;
   logic [31:0] HI_in;
   logic        HIWrite, LOWrite, md_busy;

   int n_checks = 0;
   int n_fail   = 0;

   wb_muldiv #(.ITER(ITER)) dut (
      .clk      (clk),
      .CLR_n    (CLR_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_op    (in_op),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_dst   (in_dst),
      .WbData   (WbData),
      .WbRegNum (WbRegNum),
      .RegWrite (RegWrite),
      .HI_in    (HI_in),
      .HIWrite  (HIWrite),
      .LOWrite  (LOWrite),
      .md_busy  (md_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: {HI, LO} from plain arithmetic on the architectural rules.
   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, q, r;
      logic [31:0] uq, ur;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      case (op)
         3'd2: begin q = sa * sb; return q; end
         3'd3: return {32'd0, a} * {32'd0, b};
         3'd4: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         3'd5: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            uq = a / b;
            ur = a % b;
            return {ur, uq};
         end
         default: return 64'd0;
      endcase
   endfunction

   // RegWrite and LOWrite must never be asserted together.
   always @(negedge clk) begin
      if (CLR_n === 1'b1) check("regwrite_lowrite_excl", 64'(RegWrite & LOWrite), 64'd0);
   end

   task automatic do_single(input logic [2:0] op, input logic [31:0] a, input logic [4:0] dst, input string name);
      logic exp_rw;
      exp_rw = (op == 3'd1) && (dst != 5'd0);
      @(negedge clk);
      check({name, "_ready"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = $urandom;
      in_dst   = dst;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check({name, "_regwrite"}, 64'(RegWrite), 64'(exp_rw));
      check({name, "_hiwrite"}, 64'(HIWrite), 64'(op == 3'd6));
      check({name, "_lowrite"}, 64'(LOWrite), 64'(op == 3'd7));
      if (exp_rw) begin
         check({name, "_regnum"}, 64'(WbRegNum), 64'(dst));
         check({name, "_wbdata"}, 64'(WbData), 64'(a));
      end
      if (op == 3'd6) check({name, "_hi_in"}, 64'(HI_in), 64'(a));
      if (op == 3'd7) check({name, "_lo_data"}, 64'(WbData), 64'(a));
   endtask

   task automatic do_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string name);
      int   lat, bad;
      logic got;
      @(negedge clk);
      check({name, "_ready"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_dst   = 5'd0;
      @(posedge clk);
      #1;
      // MEM keeps presenting a REG op that must be held off while busy.
      in_op  = 3'd1;
      in_dst = 5'd9;
      in_a   = $urandom;
      in_b   = $urandom;
      lat = 1;
      bad = 0;
      got = 1'b0;
      while (!got && lat <= 100) begin
         if (HIWrite === 1'b1 && LOWrite === 1'b1) got = 1'b1;
         else begin
            if (in_ready !== 1'b0 || md_busy !== 1'b1 || RegWrite !== 1'b0 ||
                HIWrite !== 1'b0 || LOWrite !== 1'b0) bad++;
            @(posedge clk);
            #1;
            lat++;
         end
      end
      in_valid = 1'b0;
      check({name, "_latency"}, 64'(lat), 64'(ITER + 1));
      check({name, "_busy_hold"}, 64'(bad), 64'd0);
      check({name, "_done_flags"}, 64'({in_ready, md_busy, RegWrite}), 64'(3'b010));
      check({name, "_hilo"}, {HI_in, WbData}, exp);
      @(posedge clk);
      #1;
      check({name, "_after"}, 64'({in_ready, md_busy, HIWrite, LOWrite}), 64'(4'b1000));
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  dst;
      logic [63:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int bad;
      logic [2:0]  rop;
      logic [31:0] ra, rb;

      vecs.push_back('{3'd1, 32'h1234_5678, 32'd0, 5'd5, 64'h0, "reg_dst5"});
      vecs.push_back('{3'd1, 32'h1234_5678, 32'd0, 5'd0, 64'h0, "reg_dst0"});
      vecs.push_back('{3'd2, 32'hFFFF_FFFD, 32'd5, 5'd0, 64'hFFFF_FFFF_FFFF_FFF1, "mult_neg3x5"});
      vecs.push_back('{3'd5, 32'd100, 32'd7, 5'd0, {32'd2, 32'd14}, "divu_100_7"});
      vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2, 5'd0, 64'hFFFF_FFFF_FFFF_FFFD, "div_neg7_2"});
      vecs.push_back('{3'd5, 32'h55, 32'd0, 5'd0, {32'h55, 32'hFFFF_FFFF}, "divu_by0"});
      vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, {32'h0, 32'h8000_0000}, "div_ovf"});
      vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 64'hFFFF_FFFE_0000_0001, "multu_max"});
      vecs.push_back('{3'd2, 32'h8000_0000, 32'h8000_0000, 5'd0, 64'h4000_0000_0000_0000, "mult_min"});
      vecs.push_back('{3'd4, 32'd7, 32'hFFFF_FFFE, 5'd0, {32'd1, 32'hFFFF_FFFD}, "div_7_neg2"});
      vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd0, 5'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, "div_by0_signed"});

      CLR_n    = 1'b0;
      in_valid = 1'b0;
      in_op    = 3'd0;
      in_a     = '0;
      in_b     = '0;
      in_dst   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", 64'(in_ready), 64'd1);
      check("reset_busy", 64'(md_busy), 64'd0);
      check("reset_enables", 64'({RegWrite, HIWrite, LOWrite}), 64'd0);
      check("reset_data", {HI_in, WbData}, 64'd0);
      check("reset_regnum", 64'(WbRegNum), 64'd0);
      @(negedge clk);
      CLR_n = 1'b1;

      foreach (vecs[i]) begin
         if (vecs[i].op == 3'd1) do_single(vecs[i].op, vecs[i].a, vecs[i].dst, vecs[i].name);
         else                    do_md(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
      end

      // MTHI then MTLO on consecutive cycles, then a quiet cycle.
      do_single(3'd6, 32'hA5A5_A5A5, 5'd0, "mthi");
      do_single(3'd7, 32'h5A5A_5A5A, 5'd0, "mtlo");
      @(posedge clk);
      #1;
      check("mt_pulse_end", 64'({HIWrite, LOWrite, RegWrite}), 64'd0);

      // Back-to-back REG writes with no bubble.
      do_single(3'd1, 32'hDEAD_BEEF, 5'd31, "reg_b2b_a");
      do_single(3'd1, 32'h0BAD_F00D, 5'd1, "reg_b2b_b");

      // Reset in the middle of a MULTU: nothing may be written afterwards.
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = 3'd3;
      in_a     = 32'h1234_5678;
      in_b     = 32'h9ABC_DEF0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("midrst_busy_before", 64'(md_busy), 64'd1);
      CLR_n = 1'b0;
      #1;
      check("midrst_busy", 64'(md_busy), 64'd0);
      check("midrst_ready", 64'(in_ready), 64'd1);
      check("midrst_enables", 64'({RegWrite, HIWrite, LOWrite}), 64'd0);
      @(negedge clk);
      CLR_n = 1'b1;
      bad = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (HIWrite !== 1'b0 || LOWrite !== 1'b0 || md_busy !== 1'b0) bad++;
      end
      check("midrst_no_write", 64'(bad), 64'd0);
      do_single(3'd1, 32'hCAFE_0001, 5'd12, "reg_after_rst");

      // Randomized mix against the arithmetic model.
      for (int k = 0; k < 24; k++) begin
         rop = 3'($urandom_range(7, 0));
         ra  = $urandom;
         rb  = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(3, 0)) : 32'($urandom);
         if (rop >= 3'd2 && rop <= 3'd5)
            do_md(rop, ra, rb, model(rop, ra, rb), $sformatf("rand%0d_md", k));
         else
            do_single(rop, ra, 5'($urandom_range(31, 0)), $sformatf("rand%0d_single", k));
      end

      repeat (2) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_muldiv.md
# wb_muldiv

Writeback-side producer for the decode stage's register-file and HI/LO write port. Accepts retired operations from the MEM stage over a valid/ready handshake, drives the single-cycle register writeback bus, and runs an iterative 32-cycle multiply/divide engine whose 64-bit result is delivered as a simultaneous HI/LO write. Sits between the MEM/WB boundary and the decode stage's `WbData`/`WbRegNum`/`RegWrite`/`HI_in`/`HIWrite`/`LOWrite` inputs.

## Interface
- `ITER`, 32: mul/div iterations, one bit per cycle.
- `clk` in 1: clock; all state updates on rising edge.
- `CLR_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: MEM stage presents an operation.
- `in_ready` out 1: block accepts the operation this cycle.
- `in_op` in 3: operation code (`wb_op_t`).
- `in_a` in 32: REG result, MTHI/MTLO data, or rs operand.
- `in_b` in 32: rt operand (mul/div only).
- `in_dst` in 5: destination register (REG only).
- `WbData` out 32: register write data; carries LO on LO writes.
- `WbRegNum` out 5: register write index.
- `RegWrite` out 1: register-file write enable.
- `HI_in` out 32: HI write data.
- `HIWrite` out 1: HI write enable.
- `LOWrite` out 1: LO write enable (data on `WbData`).
- `md_busy` out 1: mul/div in flight (accepted, HI/LO not yet written); hazard unit stalls MFHI/MFLO on it.

## Operation
- Op codes: NOP=0, REG=1, MULT=2, MULTU=3, DIV=4, DIVU=5, MTHI=6, MTLO=7.
- Accept = `in_valid && in_ready` at rising edge. `in_ready` = 1 only in IDLE.
- REG: next cycle `RegWrite`=1, `WbData`=`in_a`, `WbRegNum`=`in_dst`, for one cycle. `in_dst`=0 -> `RegWrite` stays 0.
- MTHI: next cycle `HIWrite`=1, `HI_in`=`in_a`. MTLO: next cycle `LOWrite`=1, `WbData`=`in_a`, `RegWrite`=0.
- NOP: accepted, no write.
- MULT/MULTU: shift-add on magnitudes, ITER cycles; signed result negated if operand signs differ. HI = product[63:32], LO = product[31:0].
- DIV/DIVU: restoring division on magnitudes, ITER cycles. LO = quotient (truncated toward zero), HI = remainder (sign of dividend).
- Divide by zero: LO=0xFFFFFFFF, HI=dividend (`in_a`). DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- FSM: IDLE -> (accept mul/div) BUSY -> after ITER cycles DONE -> IDLE. Single-cycle ops stay in IDLE.
- DONE: `HIWrite`=`LOWrite`=1, `HI_in`=HI, `WbData`=LO, `RegWrite`=0, exactly one cycle.
- Invariant: `RegWrite` and `LOWrite` never both 1.
- Operands latched at accept; `in_a`/`in_b` ignored afterwards.

## Timing
- Reset (any time, incl. mid-BUSY): state IDLE, iteration counter 0, all outputs 0 except `in_ready`=1. In-flight mul/div discarded; no HI/LO write.
- Write outputs are registered, one-cycle pulses; default 0 when no write.
- REG/MTHI/MTLO: accept at edge N -> write visible in cycle N+1.
- Mul/div: accept at edge N -> `md_busy`=1 from N+1 through DONE; DONE cycle = N+ITER+1; `in_ready`=1 again at N+ITER+2.
- Back-to-back single-cycle ops: one per cycle, no bubble.
- `in_valid` with `in_ready`=0: held by MEM stage; nothing latched.

## Structure
- Package `wb_pkg`: `wb_op_t` enum, `ITER_DEFAULT`=32, `DIV0_LO`=32'hFFFFFFFF.
- Sub-module `muldiv_iter`: start pulse, op, operands in; done pulse, hi/lo out. Top holds handshake, FSM, and output registers.

## Test plan
- REG, `in_a`=0x12345678, `in_dst`=5 -> next cycle `RegWrite`=1, `WbRegNum`=5, `WbData`=0x12345678; same with `in_dst`=0 -> `RegWrite`=0.
- MULT 0xFFFFFFFD × 5 -> DONE 33 cycles after accept: HI=0xFFFFFFFF, LO=0xFFFFFFF1; `in_ready`=0 throughout.
- DIVU 100 / 7 -> LO=14, HI=2; DIV 0xFFFFFFF9 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 0x55 / 0 -> LO=0xFFFFFFFF, HI=0x55; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0xA5A5A5A5 then MTLO 0x5A5A5A5A on consecutive cycles -> `HIWrite` pulse, then `LOWrite` pulse with `WbData`=0x5A5A5A5A, `RegWrite`=0.
- MULTU started, `CLR_n` low at iteration 10 -> no HI/LO write, `md_busy`=0, `in_ready`=1; next REG accepted normally.
